// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared types and constants for the pixel stream generator
package pixel_stream_pkg;
    localparam int PIX_W = 8;
    localparam int BYTES = 4;
    typedef enum logic [1:0] {PAT_SOLID, PAT_HRAMP, PAT_VRAMP, PAT_CHECK} pattern_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;
endpackage

// File: rtl/pixel_stream_gen_calc.sv
// pixel_pattern_calc: combinational pixel word for beat (x, y) under pattern sel
module pixel_pattern_calc
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int XW = 10,
    parameter int YW = 9,
    parameter logic [7:0] FILL = 8'h80
) (
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  pattern_t              sel,
    output logic [DATA_WIDTH-1:0] pix
);
    localparam int NB = DATA_WIDTH / PIX_W;
    logic [31:0] yy;
    assign yy = 32'(y);
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] h;
        assign h = 8'((32'(x) * NB) + i);
        assign pix[i*8 +: 8] = (sel == PAT_SOLID) ? FILL :
                               (sel == PAT_HRAMP) ? h :
                               (sel == PAT_VRAMP) ? yy[7:0] :
                               (h[3] ^ yy[3])     ? 8'hFF : 8'h00;
    end
endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: AXI4-Stream test-pattern frame source; PIXEL_GEN_STATS_EN adds stall_count
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH = BYTES * PIX_W,
    parameter int H_BEATS = 640,
    parameter int V_LINES = 480,
    parameter int GAP_CYCLES = 0,
    parameter logic [7:0] FILL = 8'h80
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    output logic                  m_axis_user,
    input  logic                  m_axis_ready,
    output logic                  frame_done,
    output logic [15:0]           frame_count
`ifdef PIXEL_GEN_STATS_EN
    ,output logic [31:0]          stall_count
`endif
);
    localparam int XW = H_BEATS > 1 ? $clog2(H_BEATS) : 1;
    localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [XW-1:0] XMAX = XW'(H_BEATS - 1);
    localparam logic [YW-1:0] YMAX = YW'(V_LINES - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t state, state_n;
    pattern_t sel_q, sel_n, csel;
    logic [XW-1:0] x, x_n, nx, cx;
    logic [YW-1:0] y, y_n, ny, cy;
    logic [GW-1:0] gap, gap_n;
    logic [DATA_WIDTH-1:0] pix, data_n;
    logic valid_n, last_n, user_n, hs, final_beat, start;

    pixel_pattern_calc #(.DATA_WIDTH(DATA_WIDTH), .XW(XW), .YW(YW), .FILL(FILL)) u_calc (
        .x(cx), .y(cy), .sel(csel), .pix(pix)
    );

    // Next-state, next-beat coordinates and registered stream outputs
    always_comb begin
        hs = m_axis_valid & m_axis_ready;
        final_beat = hs && x == XMAX && y == YMAX;
        start = enable && (state == ST_IDLE ||
                           (state == ST_RUN && final_beat && GAP_CYCLES == 0) ||
                           (state == ST_GAP && gap == GLAST));
        nx = (x == XMAX) ? '0 : x + 1'b1;
        ny = (x != XMAX) ? y : (y == YMAX) ? '0 : y + 1'b1;
        cx = start ? '0 : nx;
        cy = start ? '0 : ny;
        csel = start ? pattern_t'(pattern_sel) : sel_q;
        state_n = state;
        sel_n = sel_q;
        x_n = x;
        y_n = y;
        gap_n = gap;
        valid_n = m_axis_valid;
        data_n = m_axis_data;
        last_n = m_axis_last;
        user_n = m_axis_user;
        if (start || (hs && !final_beat)) begin
            state_n = ST_RUN;
            sel_n = csel;
            x_n = cx;
            y_n = cy;
            valid_n = 1'b1;
            data_n = pix;
            last_n = cx == XMAX;
            user_n = start;
        end else if (final_beat) begin
            state_n = GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
            x_n = '0;
            y_n = '0;
            gap_n = '0;
            valid_n = 1'b0;
            last_n = 1'b0;
            user_n = 1'b0;
        end else if (state == ST_GAP) begin
            gap_n = gap + 1'b1;
            state_n = gap == GLAST ? ST_IDLE : ST_GAP;
        end
    end

    // State, counters and stream output registers
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state <= ST_IDLE;
            sel_q <= PAT_SOLID;
            x <= '0;
            y <= '0;
            gap <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data <= '0;
            m_axis_last <= 1'b0;
            m_axis_user <= 1'b0;
            frame_done <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_n;
            sel_q <= sel_n;
            x <= x_n;
            y <= y_n;
            gap <= gap_n;
            m_axis_valid <= valid_n;
            m_axis_data <= data_n;
            m_axis_last <= last_n;
            m_axis_user <= user_n;
            frame_done <= final_beat;
            frame_count <= frame_count + 16'(final_beat);
        end
    end

`ifdef PIXEL_GEN_STATS_EN
    // Saturating count of cycles where a beat is offered but not taken
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)
            stall_count <= '0;
        else if (m_axis_valid && !m_axis_ready && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
`endif
endmodule
